// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one registered memory strobe bus between the PPU,
// DMA and CPU masters and routes read data back to the owner of each access.
// Ports:
//   I_CLK, I_SYNC_RESET          clock, synchronous active-high reset
//   I_PPU_* / O_PPU_*            PPU read-only request, grant, read return
//   I_DMA_* / O_DMA_*            DMA read/write request, grant, read return
//   I_CPU_* / O_CPU_*            CPU read/write request, grant, read return
//   O_MEM_*, I_MEM_RDATA         registered bus toward the memory router
//   O_OWNER                      owner of the current bus cycle (0 none,
//                                1 CPU, 2 DMA, 3 PPU)
module mem_bus_arbiter #(
   parameter int unsigned DMA_BURST_MAX = 16
) (
   input  logic        I_CLK,
   input  logic        I_SYNC_RESET,
   input  logic        I_PPU_REQ,
   input  logic [15:0] I_PPU_ADDR,
   output logic        O_PPU_GNT,
   output logic [7:0]  O_PPU_RDATA,
   output logic        O_PPU_RDATA_VALID,
   input  logic        I_DMA_REQ,
   input  logic [15:0] I_DMA_ADDR,
   input  logic        I_DMA_WE_L,
   input  logic [7:0]  I_DMA_WDATA,
   output logic        O_DMA_GNT,
   output logic [7:0]  O_DMA_RDATA,
   output logic        O_DMA_RDATA_VALID,
   input  logic        I_CPU_REQ,
   input  logic [15:0] I_CPU_ADDR,
   input  logic        I_CPU_WE_L,
   input  logic [7:0]  I_CPU_WDATA,
   output logic        O_CPU_GNT,
   output logic [7:0]  O_CPU_RDATA,
   output logic        O_CPU_RDATA_VALID,
   output logic [15:0] O_MEM_ADDR,
   output logic [7:0]  O_MEM_WDATA,
   output logic        O_MEM_WE_L,
   output logic        O_MEM_RE_L,
   input  logic [7:0]  I_MEM_RDATA,
   output logic [1:0]  O_OWNER
);

   localparam logic [1:0] OWN_NONE = 2'b00;
   localparam logic [1:0] OWN_CPU  = 2'b01;
   localparam logic [1:0] OWN_DMA  = 2'b10;
   localparam logic [1:0] OWN_PPU  = 2'b11;
   localparam logic [7:0] RUN_MAX  = 8'(DMA_BURST_MAX);

   logic [7:0]  dma_run_q, dma_run_d;
   logic        force_cpu;
   logic        ppu_gnt, dma_gnt, cpu_gnt;

   logic [15:0] addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        we_l_q, we_l_d;
   logic        re_l_q, re_l_d;
   logic [1:0]  owner_q, owner_d;

   logic [7:0]  ppu_rdata_q, dma_rdata_q, cpu_rdata_q;
   logic        ppu_vld_q, dma_vld_q, cpu_vld_q;

   // Once the DMA has used up its burst allowance, a waiting CPU takes
   // the next slot the PPU leaves free.
   always_comb begin
      force_cpu = (dma_run_q == RUN_MAX) && I_CPU_REQ && !I_PPU_REQ;
      ppu_gnt   = !I_SYNC_RESET && I_PPU_REQ;
      dma_gnt   = !I_SYNC_RESET && !I_PPU_REQ && I_DMA_REQ && !force_cpu;
      cpu_gnt   = !I_SYNC_RESET && !I_PPU_REQ && I_CPU_REQ
                  && (!I_DMA_REQ || force_cpu);
   end

   always_comb begin
      if (!I_DMA_REQ || cpu_gnt)
         dma_run_d = 8'h00;
      else if (dma_gnt && dma_run_q != RUN_MAX)
         dma_run_d = dma_run_q + 8'h01;
      else
         dma_run_d = dma_run_q;
   end

   // Next bus cycle; address and write data hold when the bus idles.
   always_comb begin
      addr_d  = addr_q;
      wdata_d = wdata_q;
      we_l_d  = 1'b1;
      re_l_d  = 1'b1;
      owner_d = OWN_NONE;
      unique case (1'b1)
         ppu_gnt: begin
            addr_d  = I_PPU_ADDR;
            re_l_d  = 1'b0;
            owner_d = OWN_PPU;
         end
         dma_gnt: begin
            addr_d  = I_DMA_ADDR;
            owner_d = OWN_DMA;
            if (!I_DMA_WE_L) begin
               wdata_d = I_DMA_WDATA;
               we_l_d  = 1'b0;
            end else begin
               re_l_d  = 1'b0;
            end
         end
         cpu_gnt: begin
            addr_d  = I_CPU_ADDR;
            owner_d = OWN_CPU;
            if (!I_CPU_WE_L) begin
               wdata_d = I_CPU_WDATA;
               we_l_d  = 1'b0;
            end else begin
               re_l_d  = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge I_CLK) begin
      if (I_SYNC_RESET) begin
         dma_run_q   <= 8'h00;
         addr_q      <= 16'h0000;
         wdata_q     <= 8'h00;
         we_l_q      <= 1'b1;
         re_l_q      <= 1'b1;
         owner_q     <= OWN_NONE;
         ppu_vld_q   <= 1'b0;
         dma_vld_q   <= 1'b0;
         cpu_vld_q   <= 1'b0;
         ppu_rdata_q <= 8'h00;
         dma_rdata_q <= 8'h00;
         cpu_rdata_q <= 8'h00;
      end else begin
         dma_run_q <= dma_run_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         we_l_q    <= we_l_d;
         re_l_q    <= re_l_d;
         owner_q   <= owner_d;
         // Read data lands at the end of the strobe cycle.
         ppu_vld_q <= !re_l_q && owner_q == OWN_PPU;
         dma_vld_q <= !re_l_q && owner_q == OWN_DMA;
         cpu_vld_q <= !re_l_q && owner_q == OWN_CPU;
         if (!re_l_q && owner_q == OWN_PPU)
            ppu_rdata_q <= I_MEM_RDATA;
         if (!re_l_q && owner_q == OWN_DMA)
            dma_rdata_q <= I_MEM_RDATA;
         if (!re_l_q && owner_q == OWN_CPU)
            cpu_rdata_q <= I_MEM_RDATA;
      end
   end

   assign O_PPU_GNT         = ppu_gnt;
   assign O_DMA_GNT         = dma_gnt;
   assign O_CPU_GNT         = cpu_gnt;
   assign O_PPU_RDATA       = ppu_rdata_q;
   assign O_DMA_RDATA       = dma_rdata_q;
   assign O_CPU_RDATA       = cpu_rdata_q;
   assign O_PPU_RDATA_VALID = ppu_vld_q;
   assign O_DMA_RDATA_VALID = dma_vld_q;
   assign O_CPU_RDATA_VALID = cpu_vld_q;
   assign O_MEM_ADDR        = addr_q;
   assign O_MEM_WDATA       = wdata_q;
   assign O_MEM_WE_L        = we_l_q;
   assign O_MEM_RE_L        = re_l_q;
   assign O_OWNER           = owner_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed bench for mem_bus_arbiter with a small
// router model (default read pattern addr[15:8]^addr[7:0], last write held).
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        ppu_req, dma_req, cpu_req;
   logic [15:0] ppu_addr, dma_addr, cpu_addr;
   logic        dma_we_l, cpu_we_l;
   logic [7:0]  dma_wdata, cpu_wdata;
   logic        ppu_gnt, dma_gnt, cpu_gnt;
   logic [7:0]  ppu_rdata, dma_rdata, cpu_rdata;
   logic        ppu_vld, dma_vld, cpu_vld;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we_l, mem_re_l;
   logic [7:0]  mem_rdata = 8'h00;
   logic [1:0]  owner;

   logic        ovr_en = 1'b0;
   logic [7:0]  ovr_val = 8'h00;
   logic        wr_v = 1'b0;
   logic [15:0] wr_a = 16'h0000;
   logic [7:0]  wr_d = 8'h00;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.DMA_BURST_MAX(16)) dut (
      .I_CLK(clk), .I_SYNC_RESET(rst),
      .I_PPU_REQ(ppu_req), .I_PPU_ADDR(ppu_addr),
      .O_PPU_GNT(ppu_gnt), .O_PPU_RDATA(ppu_rdata),
      .O_PPU_RDATA_VALID(ppu_vld),
      .I_DMA_REQ(dma_req), .I_DMA_ADDR(dma_addr),
      .I_DMA_WE_L(dma_we_l), .I_DMA_WDATA(dma_wdata),
      .O_DMA_GNT(dma_gnt), .O_DMA_RDATA(dma_rdata),
      .O_DMA_RDATA_VALID(dma_vld),
      .I_CPU_REQ(cpu_req), .I_CPU_ADDR(cpu_addr),
      .I_CPU_WE_L(cpu_we_l), .I_CPU_WDATA(cpu_wdata),
      .O_CPU_GNT(cpu_gnt), .O_CPU_RDATA(cpu_rdata),
      .O_CPU_RDATA_VALID(cpu_vld),
      .O_MEM_ADDR(mem_addr), .O_MEM_WDATA(mem_wdata),
      .O_MEM_WE_L(mem_we_l), .O_MEM_RE_L(mem_re_l),
      .I_MEM_RDATA(mem_rdata), .O_OWNER(owner)
   );

   always @(posedge clk) begin
      if (!mem_we_l) begin
         wr_v <= 1'b1;
         wr_a <= mem_addr;
         wr_d <= mem_wdata;
      end
   end

   always @(negedge clk) begin
      if (ovr_en)
         mem_rdata <= ovr_val;
      else if (wr_v && wr_a == mem_addr)
         mem_rdata <= wr_d;
      else
         mem_rdata <= mem_addr[15:8] ^ mem_addr[7:0];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      ppu_req = 1'b0;
      dma_req = 1'b0;
      cpu_req = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      ppu_req = 1'b1; dma_req = 1'b1; cpu_req = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         vecs++;
         if ({ppu_gnt, dma_gnt, cpu_gnt} !== 3'b000) begin
            errs++;
            $display("FAIL reset_gnt[%0d]: got %b want 000", i,
                     {ppu_gnt, dma_gnt, cpu_gnt});
         end
         tick();
      end
      rst = 1'b0;
      idle_all();
      @(negedge clk);
      vecs++;
      if ({mem_we_l, mem_re_l, owner} !== 4'b1100) begin
         errs++;
         $display("FAIL reset_bus: got %b want 1100",
                  {mem_we_l, mem_re_l, owner});
      end
      vecs++;
      if ({ppu_vld, dma_vld, cpu_vld} !== 3'b000) begin
         errs++;
         $display("FAIL reset_vld: got %b want 000",
                  {ppu_vld, dma_vld, cpu_vld});
      end
      vecs++;
      if ({mem_addr, mem_wdata, ppu_rdata, dma_rdata, cpu_rdata} !== 48'h0) begin
         errs++;
         $display("FAIL reset_data: got %h want 0",
                  {mem_addr, mem_wdata, ppu_rdata, dma_rdata, cpu_rdata});
      end
      tick();
   endtask

   task automatic test_cpu_read();
      ovr_en = 1'b1; ovr_val = 8'h5A;
      cpu_req = 1'b1; cpu_addr = 16'hC000; cpu_we_l = 1'b1;
      @(negedge clk);
      vecs++;
      if ({ppu_gnt, dma_gnt, cpu_gnt} !== 3'b001) begin
         errs++;
         $display("FAIL cpu_rd_gnt: got %b want 001",
                  {ppu_gnt, dma_gnt, cpu_gnt});
      end
      tick();
      cpu_req = 1'b0;
      @(negedge clk);
      vecs++;
      if ({mem_we_l, mem_re_l, owner, mem_addr} !== {4'b1001, 16'hC000}) begin
         errs++;
         $display("FAIL cpu_rd_bus: got %h want 9c000",
                  {mem_we_l, mem_re_l, owner, mem_addr});
      end
      vecs++;
      if (cpu_vld !== 1'b0) begin
         errs++;
         $display("FAIL cpu_rd_early_vld: got %b want 0", cpu_vld);
      end
      tick();
      @(negedge clk);
      vecs++;
      if ({cpu_vld, cpu_rdata} !== 9'h15A) begin
         errs++;
         $display("FAIL cpu_rd_data: got %h want 15a", {cpu_vld, cpu_rdata});
      end
      vecs++;
      if ({mem_re_l, owner} !== 3'b100) begin
         errs++;
         $display("FAIL cpu_rd_idle: got %b want 100", {mem_re_l, owner});
      end
      tick();
      @(negedge clk);
      vecs++;
      if ({cpu_vld, cpu_rdata} !== 9'h05A) begin
         errs++;
         $display("FAIL cpu_rd_hold: got %h want 05a", {cpu_vld, cpu_rdata});
      end
      ovr_en = 1'b0;
      tick();
   endtask

   task automatic test_write_then_read();
      cpu_req = 1'b1; cpu_addr = 16'hFF01;
      cpu_we_l = 1'b0; cpu_wdata = 8'h3C;
      @(negedge clk);
      vecs++;
      if (cpu_gnt !== 1'b1) begin
         errs++;
         $display("FAIL wr_gnt: got %b want 1", cpu_gnt);
      end
      tick();
      cpu_req = 1'b0; cpu_we_l = 1'b1;
      dma_req = 1'b1; dma_addr = 16'hFF01; dma_we_l = 1'b1;
      @(negedge clk);
      vecs++;
      if ({mem_we_l, mem_re_l, owner, mem_wdata, mem_addr}
          !== {4'b0101, 8'h3C, 16'hFF01}) begin
         errs++;
         $display("FAIL wr_bus: got %h want 53cff01",
                  {mem_we_l, mem_re_l, owner, mem_wdata, mem_addr});
      end
      vecs++;
      if (dma_gnt !== 1'b1) begin
         errs++;
         $display("FAIL rd_after_wr_gnt: got %b want 1", dma_gnt);
      end
      tick();
      dma_req = 1'b0;
      @(negedge clk);
      vecs++;
      if ({mem_we_l, mem_re_l, owner, mem_addr} !== {4'b1010, 16'hFF01}) begin
         errs++;
         $display("FAIL rd_after_wr_bus: got %h want aff01",
                  {mem_we_l, mem_re_l, owner, mem_addr});
      end
      vecs++;
      if (cpu_vld !== 1'b0) begin
         errs++;
         $display("FAIL wr_no_vld: got %b want 0", cpu_vld);
      end
      tick();
      @(negedge clk);
      vecs++;
      if ({dma_vld, dma_rdata, cpu_vld} !== {1'b1, 8'h3C, 1'b0}) begin
         errs++;
         $display("FAIL rd_after_wr_data: got %h want 278",
                  {dma_vld, dma_rdata, cpu_vld});
      end
      tick();
   endtask

   task automatic test_ppu_priority();
      dma_addr = 16'h1234; dma_we_l = 1'b1;
      cpu_addr = 16'h2345; cpu_we_l = 1'b1;
      for (int c = 0; c < 8; c++) begin
         ppu_req  = (c < 4);
         ppu_addr = 16'h8000 + 16'(c);
         dma_req  = (c < 5);
         cpu_req  = (c < 6);
         @(negedge clk);
         vecs++;
         if ({ppu_gnt, dma_gnt, cpu_gnt} !== {c < 4, c == 4, c == 5}) begin
            errs++;
            $display("FAIL prio_gnt[%0d]: got %b want %b", c,
                     {ppu_gnt, dma_gnt, cpu_gnt}, {c < 4, c == 4, c == 5});
         end
         vecs++;
         if (ppu_vld !== (c >= 2 && c <= 5)) begin
            errs++;
            $display("FAIL prio_ppu_vld[%0d]: got %b want %b", c,
                     ppu_vld, (c >= 2 && c <= 5));
         end
         if (c >= 2 && c <= 5) begin
            vecs++;
            if (ppu_rdata !== 8'h80 + 8'(c - 2)) begin
               errs++;
               $display("FAIL prio_ppu_data[%0d]: got %h want %h", c,
                        ppu_rdata, 8'h80 + 8'(c - 2));
            end
         end
         if (c == 6) begin
            vecs++;
            if ({dma_vld, dma_rdata} !== 9'h126) begin
               errs++;
               $display("FAIL prio_dma_data: got %h want 126",
                        {dma_vld, dma_rdata});
            end
         end
         if (c == 7) begin
            vecs++;
            if ({cpu_vld, cpu_rdata} !== 9'h166) begin
               errs++;
               $display("FAIL prio_cpu_data: got %h want 166",
                        {cpu_vld, cpu_rdata});
            end
         end
         tick();
      end
      idle_all();
   endtask

   task automatic test_burst();
      dma_req = 1'b1; dma_addr = 16'h4000; dma_we_l = 1'b1;
      cpu_req = 1'b1; cpu_addr = 16'h5000; cpu_we_l = 1'b1;
      for (int k = 1; k <= 51; k++) begin
         @(negedge clk);
         vecs++;
         if ({dma_gnt, cpu_gnt} !== {k % 17 != 0, k % 17 == 0}) begin
            errs++;
            $display("FAIL burst_share[%0d]: got %b want %b", k,
                     {dma_gnt, cpu_gnt}, {k % 17 != 0, k % 17 == 0});
         end
         tick();
      end
      cpu_req = 1'b0;
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk);
         vecs++;
         if ({dma_gnt, cpu_gnt} !== 2'b10) begin
            errs++;
            $display("FAIL burst_alone[%0d]: got %b want 10", k,
                     {dma_gnt, cpu_gnt});
         end
         tick();
      end
      // Saturated counter: a newly arriving CPU wins at once.
      cpu_req = 1'b1;
      @(negedge clk);
      vecs++;
      if ({dma_gnt, cpu_gnt} !== 2'b01) begin
         errs++;
         $display("FAIL burst_sat_cpu: got %b want 01", {dma_gnt, cpu_gnt});
      end
      tick();
      @(negedge clk);
      vecs++;
      if ({dma_gnt, cpu_gnt} !== 2'b10) begin
         errs++;
         $display("FAIL burst_after_cpu: got %b want 10", {dma_gnt, cpu_gnt});
      end
      tick();
      idle_all();
      for (int k = 0; k < 3; k++) tick();
   endtask

   task automatic test_reset_mid();
      dma_req = 1'b1; dma_addr = 16'h4444; dma_we_l = 1'b1;
      @(negedge clk);
      vecs++;
      if (dma_gnt !== 1'b1) begin
         errs++;
         $display("FAIL rstmid_gnt: got %b want 1", dma_gnt);
      end
      tick();
      dma_req = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      vecs++;
      if ({mem_re_l, owner} !== 3'b010) begin
         errs++;
         $display("FAIL rstmid_strobe: got %b want 010", {mem_re_l, owner});
      end
      tick();
      rst = 1'b0;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         vecs++;
         if ({dma_vld, mem_re_l, mem_we_l, owner} !== 5'b01100) begin
            errs++;
            $display("FAIL rstmid_idle[%0d]: got %b want 01100", c,
                     {dma_vld, mem_re_l, mem_we_l, owner});
         end
         tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      idle_all();
      ppu_addr = 16'h0; dma_addr = 16'h0; cpu_addr = 16'h0;
      dma_we_l = 1'b1; cpu_we_l = 1'b1;
      dma_wdata = 8'h0; cpu_wdata = 8'h0;
      tick();
      test_reset();
      test_cpu_read();
      test_write_then_read();
      test_ppu_priority();
      test_burst();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Arbitrates the single shared memory bus (cartridge, WRAM, VRAM/LCD RAM, OAM, I/O registers behind the memory router) between three requesters: PPU (read-only), DMA engine (read/write) and CPU (read/write). It sits between those masters and the memory router's master port. It issues at most one access per cycle on a registered memory strobe interface and returns read data to the owning requester. A bounded DMA burst length guarantees the CPU a slot during long DMA transfers.

## Interface
- DMA_BURST_MAX, 16: consecutive DMA accepts allowed while the CPU is requesting; the next slot is forced to the CPU. Range 1..255.

Ports:
- I_CLK  in  1  system clock; all state updates on rising edge
- I_SYNC_RESET  in  1  synchronous, active-high reset
- I_PPU_REQ  in  1  PPU read request
- I_PPU_ADDR  in  16  PPU read address
- O_PPU_GNT  out  1  PPU request accepted this cycle (combinational)
- O_PPU_RDATA  out  8  PPU read data
- O_PPU_RDATA_VALID  out  1  O_PPU_RDATA valid this cycle
- I_DMA_REQ  in  1  DMA request
- I_DMA_ADDR  in  16  DMA address
- I_DMA_WE_L  in  1  0 = write, 1 = read
- I_DMA_WDATA  in  8  DMA write data
- O_DMA_GNT  out  1  DMA request accepted (combinational)
- O_DMA_RDATA  out  8  DMA read data
- O_DMA_RDATA_VALID  out  1  DMA read data valid
- I_CPU_REQ, I_CPU_ADDR[15:0], I_CPU_WE_L, I_CPU_WDATA[7:0]  in  same meaning as the DMA ports
- O_CPU_GNT, O_CPU_RDATA[7:0], O_CPU_RDATA_VALID  out  same meaning as the DMA ports
- O_MEM_ADDR  out  16  registered bus address
- O_MEM_WDATA  out  8  registered write data
- O_MEM_WE_L  out  1  registered write strobe, active low
- O_MEM_RE_L  out  1  registered read strobe, active low
- I_MEM_RDATA  in  8  read data from the router; valid by the end of the strobe cycle
- O_OWNER  out  2  owner of the current bus cycle: 00 none, 01 CPU, 10 DMA, 11 PPU

## Operation
- Accept: in cycle N, at most one GNT is high. It is a combinational function of the three REQs, the burst counter `dma_run` and a CPU-pending condition. A request is consumed at the edge ending cycle N when its REQ and GNT are both high.
- Priority: PPU > DMA > CPU. Exception: if `dma_run == DMA_BURST_MAX` and I_CPU_REQ is high and the PPU is not requesting, the CPU wins over the DMA.
- `dma_run` (8 bit):
  - increments on each DMA accept, saturating at DMA_BURST_MAX;
  - clears on a CPU accept;
  - clears on any cycle where I_DMA_REQ is low.
  - A PPU accept leaves it unchanged.
- Bus cycle N+1 (registered from the cycle-N accept):
  - O_MEM_ADDR = accepted address;
  - O_MEM_WDATA = accepted write data for writes;
  - exactly one of O_MEM_WE_L / O_MEM_RE_L is low; PPU accesses are always reads;
  - O_OWNER = accepted requester.
- Idle bus cycle (no accept in N):
  - both strobes high;
  - ADDR/WDATA hold their last values;
  - O_OWNER = 00.
- Read return: for a read on the bus in cycle N+1, I_MEM_RDATA is captured at the end of N+1. It is presented on the owner's RDATA with RDATA_VALID high for exactly cycle N+2.
- Each RDATA output holds its last value when its VALID is low.
- Writes produce no VALID.
- Back-to-back: a requester keeping REQ high after a GNT issues a new access. Throughput is 1 access/cycle. Pipelined reads return in order, one per cycle.
- The DMA burst limit applies only while the CPU requests; an unopposed DMA is never throttled.
- The PPU may starve the CPU and DMA indefinitely; bounding PPU demand is the PPU's responsibility.

## Timing
- Reset (edge with I_SYNC_RESET high), outputs on the following cycle:
  - all GNT = 0 (GNTs forced low while reset is asserted);
  - all RDATA_VALID = 0, all RDATA = 8'h00;
  - O_MEM_ADDR = 16'h0000, O_MEM_WDATA = 8'h00;
  - O_MEM_WE_L = O_MEM_RE_L = 1, O_OWNER = 00;
  - `dma_run` = 0.
- Reset mid-operation: in-flight bus cycles and pending read returns are discarded; no VALID is produced for them.
- Latency: REQ & GNT in cycle N → strobe in N+1 → RDATA_VALID in N+2. Minimum read latency is 2 cycles from the accept cycle.
- Simultaneous requests from all three requesters: PPU is granted every cycle it requests. The others see GNT = 0 and must hold REQ, ADDR, WE_L and WDATA stable until granted.
- A write by one requester in N+1 followed by a read of the same address in N+2 returns the written value (the router is in order).
- Saturation boundary: with DMA and CPU both requesting continuously and DMA_BURST_MAX = 16, the grant pattern is 16 DMA, 1 CPU, repeating. The CPU accept clears `dma_run`.

## Test plan
- Reset: assert I_SYNC_RESET for 2 cycles with all REQs high → all GNT = 0 throughout; strobes high, O_OWNER = 00, VALIDs 0 in the cycle after release.
- Single CPU read of 16'hC000 with I_MEM_RDATA = 8'h5A → O_CPU_GNT in N; O_MEM_RE_L = 0, O_MEM_ADDR = C000, O_OWNER = 01 in N+1; O_CPU_RDATA = 5A with VALID in N+2 only.
- CPU write 8'h3C to FF01 immediately followed by DMA read of FF01 → WE_L low in N+1 with WDATA 3C; RE_L low in N+2; O_DMA_RDATA = 3C valid in N+3; no CPU VALID.
- All three REQ high for 4 cycles, PPU reading 8000..8003 → PPU granted 4 consecutive cycles, 4 in-order PPU VALIDs; DMA and CPU granted only afterwards, DMA first.
- DMA and CPU continuously requesting, DMA_BURST_MAX = 16 → CPU granted on accept cycles 17, 34 and 51; DMA on all others; with the CPU idle, DMA is granted 40 consecutive cycles.
- Reset asserted in the cycle after a DMA read accept → no DMA VALID afterwards; the bus is idle after release.
